// File: rtl/crc_serial_engine_if.sv
// Bit-stream interface of the serial CRC engine.
// The master side is the bit source and the result consumer.
// The slave side is the engine itself.
interface crc_serial_engine_if #(
    parameter int WIDTH = 8
) ();
    logic             enable;
    logic             crc_in;
    logic             last;
    logic             mode;
    logic             in_ready;
    logic             crc_out;
    logic             out_valid;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] crc_value;
    logic             crc_ok;

    modport master (
        output enable, crc_in, last, mode,
        input  in_ready, crc_out, out_valid, busy, done, crc_value, crc_ok
    );

    modport slave (
        input  enable, crc_in, last, mode,
        output in_ready, crc_out, out_valid, busy, done, crc_value, crc_ok
    );
endinterface

// File: rtl/crc_serial_engine.sv
// Serial CRC engine with framing.
// Generate mode echoes the data stream and then appends the CRC MSB-first.
// Check mode echoes the frame and reports whether the register matches the
// expected residue once the frame completes.
module crc_serial_engine #(
    parameter int               WIDTH   = 8,
    parameter logic [WIDTH-1:0] POLY    = WIDTH'(8'h07),
    parameter logic [WIDTH-1:0] INIT    = {WIDTH{1'b0}},
    parameter logic [WIDTH-1:0] XOROUT  = {WIDTH{1'b0}},
    parameter logic [WIDTH-1:0] RESIDUE = {WIDTH{1'b0}}
) (
    input  logic                clk,
    input  logic                rstn,
    crc_serial_engine_if.slave  bus
);
    localparam int             CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CALC   = 2'd1,
        ST_APPEND = 2'd2
    } state_t;

    // One MSB-first LFSR step of the CRC register.
    function automatic logic [WIDTH-1:0] crc_step(input logic [WIDTH-1:0] crc,
                                                  input logic             bit_in);
        logic fb;
        fb       = crc[WIDTH-1] ^ bit_in;
        crc_step = {crc[WIDTH-2:0], 1'b0} ^ (fb ? POLY : {WIDTH{1'b0}});
    endfunction

    state_t           state_r, state_next_s;
    logic [WIDTH-1:0] crc_r, crc_next_s;
    logic [WIDTH-1:0] shift_r, shift_next_s;
    logic [CNT_W-1:0] cnt_r, cnt_next_s;
    logic             mode_r, mode_next_s;
    logic             crc_out_r, crc_out_next_s;
    logic             out_valid_r, out_valid_next_s;
    logic             done_r, done_next_s;
    logic [WIDTH-1:0] crc_value_r, crc_value_next_s;
    logic             crc_ok_r, crc_ok_next_s;
    logic             busy_r;
    logic             in_ready_r;

    logic             accept_s;
    logic             mode_eff_s;
    logic [WIDTH-1:0] crc_step_s;

    // Next-state, datapath and output decode for every state.
    always_comb begin
        state_next_s     = state_r;
        crc_next_s       = crc_r;
        shift_next_s     = shift_r;
        cnt_next_s       = cnt_r;
        mode_next_s      = mode_r;
        crc_out_next_s   = crc_out_r;
        out_valid_next_s = 1'b0;
        done_next_s      = 1'b0;
        crc_value_next_s = crc_value_r;
        crc_ok_next_s    = crc_ok_r;

        accept_s   = bus.enable && (state_r != ST_APPEND);
        // Mode is only taken from the port on the first bit of a frame.
        mode_eff_s = (state_r == ST_IDLE) ? bus.mode : mode_r;
        crc_step_s = crc_step(crc_r, bus.crc_in);

        case (state_r)
            ST_IDLE, ST_CALC: begin
                if (accept_s) begin
                    crc_next_s       = crc_step_s;
                    crc_out_next_s   = bus.crc_in;
                    out_valid_next_s = 1'b1;
                    mode_next_s      = mode_eff_s;
                    state_next_s     = ST_CALC;
                    if (bus.last) begin
                        if (!mode_eff_s) begin
                            shift_next_s     = crc_step_s ^ XOROUT;
                            crc_value_next_s = crc_step_s ^ XOROUT;
                            cnt_next_s       = {CNT_W{1'b0}};
                            state_next_s     = ST_APPEND;
                        end else begin
                            crc_ok_next_s    = (crc_step_s == RESIDUE);
                            crc_value_next_s = crc_step_s ^ XOROUT;
                            done_next_s      = 1'b1;
                            crc_next_s       = INIT;
                            state_next_s     = ST_IDLE;
                        end
                    end else begin
                        done_next_s = 1'b0;
                    end
                end else begin
                    out_valid_next_s = 1'b0;
                end
            end
            ST_APPEND: begin
                crc_out_next_s   = shift_r[WIDTH-1];
                out_valid_next_s = 1'b1;
                shift_next_s     = {shift_r[WIDTH-2:0], 1'b0};
                cnt_next_s       = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                if (cnt_r == CNT_LAST) begin
                    done_next_s  = 1'b1;
                    crc_next_s   = INIT;
                    cnt_next_s   = {CNT_W{1'b0}};
                    state_next_s = ST_IDLE;
                end else begin
                    done_next_s = 1'b0;
                end
            end
            default: begin
                crc_next_s   = INIT;
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_r     <= ST_IDLE;
            crc_r       <= INIT;
            shift_r     <= {WIDTH{1'b0}};
            cnt_r       <= {CNT_W{1'b0}};
            mode_r      <= 1'b0;
            crc_out_r   <= 1'b0;
            out_valid_r <= 1'b0;
            done_r      <= 1'b0;
            crc_value_r <= {WIDTH{1'b0}};
            crc_ok_r    <= 1'b0;
            busy_r      <= 1'b0;
            in_ready_r  <= 1'b1;
        end else begin
            state_r     <= state_next_s;
            crc_r       <= crc_next_s;
            shift_r     <= shift_next_s;
            cnt_r       <= cnt_next_s;
            mode_r      <= mode_next_s;
            crc_out_r   <= crc_out_next_s;
            out_valid_r <= out_valid_next_s;
            done_r      <= done_next_s;
            crc_value_r <= crc_value_next_s;
            crc_ok_r    <= crc_ok_next_s;
            busy_r      <= (state_next_s != ST_IDLE);
            in_ready_r  <= (state_next_s != ST_APPEND);
        end
    end

    assign bus.in_ready  = in_ready_r;
    assign bus.crc_out   = crc_out_r;
    assign bus.out_valid = out_valid_r;
    assign bus.busy      = busy_r;
    assign bus.done      = done_r;
    assign bus.crc_value = crc_value_r;
    assign bus.crc_ok    = crc_ok_r;
endmodule

// File: tb/tb_crc_serial_engine.sv
// Self-checking bench for crc_serial_engine: a CRC-8 instance driven by a
// vector table, random frames and a reset-in-append sequence, plus a
// CRC-16/CCITT instance checked against the standard "123456789" vector.
module tb_crc_serial_engine;
    logic clk = 1'b0;
    logic rstn;
    int   total = 0;
    int   bad   = 0;
    bit   last_ok = 1'b0;

    always #5 clk = ~clk;

    crc_serial_engine_if #(.WIDTH(8))  if8 ();
    crc_serial_engine_if #(.WIDTH(16)) if16 ();

    crc_serial_engine #(
        .WIDTH(8), .POLY(8'h07), .INIT(8'h00), .XOROUT(8'h00), .RESIDUE(8'h00)
    ) dut8 (.clk(clk), .rstn(rstn), .bus(if8));

    crc_serial_engine #(
        .WIDTH(16), .POLY(16'h1021), .INIT(16'hFFFF), .XOROUT(16'h0000), .RESIDUE(16'h0000)
    ) dut16 (.clk(clk), .rstn(rstn), .bus(if16));

    typedef struct {
        logic [31:0] data;
        int          nbits;
        bit          md;
        logic [7:0]  exp_val;
        bit          exp_ok;
    } vec_t;

    vec_t tbl [7];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: remainder of (msg * x^w + init * x^nbits) modulo the full
    // generator polynomial, by plain polynomial long division.
    function automatic logic [31:0] model_rem(input logic [127:0] msg, input int nbits,
                                              input int w, input logic [31:0] poly,
                                              input logic [31:0] init);
        logic [127:0] d;
        logic [127:0] pf;
        logic [127:0] one;
        one = 128'd1;
        d   = (msg << w) ^ ({96'd0, init} << nbits);
        pf  = {96'd0, poly} | (one << w);
        for (int p = nbits + w - 1; p >= w; p--) begin
            if (d[p]) d = d ^ (pf << (p - w));
        end
        return d[31:0] & ((32'd1 << w) - 32'd1);
    endfunction

    // Feed one frame's data bits to the 8-bit engine, checking the echo.
    task automatic send_bits8(input logic [31:0] data, input int nbits, input bit md,
                              input int maxgap);
        logic prev;
        prev = if8.crc_out;
        for (int i = nbits - 1; i >= 0; i--) begin
            int g;
            g = (maxgap > 0) ? int'($urandom_range(maxgap, 0)) : 0;
            for (int k = 0; k < g; k++) begin
                if8.enable = 1'b0;
                if8.crc_in = 1'($urandom);
                if8.last   = 1'($urandom);
                tick();
                chk("gap_out_valid", if8.out_valid, 1'b0);
                chk("gap_crc_out_hold", if8.crc_out, prev);
            end
            chk("in_ready_data", if8.in_ready, 1'b1);
            if8.enable = 1'b1;
            if8.crc_in = data[i];
            if8.last   = (i == 0);
            // Mode must only be honoured on the first bit of the frame.
            if8.mode   = (i == nbits - 1) ? md : ~md;
            tick();
            chk("echo_valid", if8.out_valid, 1'b1);
            chk("echo_bit", if8.crc_out, data[i]);
            chk("done_data", if8.done, (i == 0) && md);
            prev = data[i];
        end
        if8.enable = 1'b0;
        if8.last   = 1'b0;
    endtask

    // Complete frame on the 8-bit engine with result checks.
    task automatic run_frame8(input logic [31:0] data, input int nbits, input bit md,
                              input int maxgap, input bit noisy,
                              input logic [7:0] exp_val, input bit exp_ok);
        send_bits8(data, nbits, md, maxgap);
        if (md) begin
            chk("chk_crc_ok", if8.crc_ok, exp_ok);
            chk("chk_crc_value", if8.crc_value, exp_val);
            chk("chk_in_ready", if8.in_ready, 1'b1);
            chk("chk_busy", if8.busy, 1'b0);
            last_ok = exp_ok;
        end else begin
            chk("gen_crc_value_early", if8.crc_value, exp_val);
            chk("gen_busy", if8.busy, 1'b1);
            for (int k = 0; k < 8; k++) begin
                chk("append_in_ready", if8.in_ready, 1'b0);
                if8.enable = noisy ? 1'($urandom) : 1'b0;
                if8.crc_in = 1'($urandom);
                if8.last   = noisy ? 1'($urandom) : 1'b0;
                tick();
                chk("append_valid", if8.out_valid, 1'b1);
                chk("append_bit", if8.crc_out, exp_val[7-k]);
                chk("append_done", if8.done, k == 7);
            end
            if8.enable = 1'b0;
            if8.last   = 1'b0;
            chk("gen_in_ready_after", if8.in_ready, 1'b1);
            chk("gen_busy_after", if8.busy, 1'b0);
            chk("gen_crc_value", if8.crc_value, exp_val);
            chk("gen_crc_ok_hold", if8.crc_ok, last_ok);
        end
    endtask

    initial begin
        logic [71:0] msg;
        logic [15:0] got16;
        logic [31:0] d;
        logic [31:0] rem;
        int          nb;
        bit          md;

        tbl[0] = '{32'h31,   8,  1'b0, 8'h97, 1'b0};
        tbl[1] = '{32'hFF,   8,  1'b0, 8'hF3, 1'b0};
        tbl[2] = '{32'h01,   8,  1'b0, 8'h07, 1'b0};
        tbl[3] = '{32'h80,   8,  1'b0, 8'h89, 1'b0};
        tbl[4] = '{32'h3197, 16, 1'b1, 8'h00, 1'b1};
        tbl[5] = '{32'h3196, 16, 1'b1, 8'h07, 1'b0};
        tbl[6] = '{32'h3097, 16, 1'b1, 8'h15, 1'b0};

        rstn = 1'b0;
        if8.enable = 1'b0;  if8.crc_in = 1'b0;  if8.last = 1'b0;  if8.mode = 1'b0;
        if16.enable = 1'b0; if16.crc_in = 1'b0; if16.last = 1'b0; if16.mode = 1'b0;
        tick();
        tick();
        chk("rst_out_valid", if8.out_valid, 1'b0);
        chk("rst_crc_out", if8.crc_out, 1'b0);
        chk("rst_done", if8.done, 1'b0);
        chk("rst_busy", if8.busy, 1'b0);
        chk("rst_in_ready", if8.in_ready, 1'b1);
        chk("rst_crc_value", if8.crc_value, 8'h00);
        chk("rst_crc_ok", if8.crc_ok, 1'b0);
        rstn = 1'b1;
        tick();

        // Table vectors, back-to-back with no idle cycles between frames.
        for (int v = 0; v < 7; v++) begin
            run_frame8(tbl[v].data, tbl[v].nbits, tbl[v].md, 0, 1'b0,
                       tbl[v].exp_val, tbl[v].exp_ok);
        end

        // 8'h31 with enable gaps and noise on the inputs during append.
        run_frame8(32'h31, 8, 1'b0, 3, 1'b1, 8'h97, 1'b0);

        // Reset during the 4th append cycle.
        send_bits8(32'h31, 8, 1'b0, 0);
        tick();
        tick();
        tick();
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        chk("midrst_out_valid", if8.out_valid, 1'b0);
        chk("midrst_crc_out", if8.crc_out, 1'b0);
        chk("midrst_done", if8.done, 1'b0);
        chk("midrst_busy", if8.busy, 1'b0);
        chk("midrst_in_ready", if8.in_ready, 1'b1);
        chk("midrst_crc_value", if8.crc_value, 8'h00);
        chk("midrst_crc_ok", if8.crc_ok, 1'b0);
        last_ok = 1'b0;
        run_frame8(32'h31, 8, 1'b0, 0, 1'b0, 8'h97, 1'b0);

        // Random frames against the long-division model.
        for (int r = 0; r < 24; r++) begin
            nb = int'($urandom_range(24, 1));
            md = 1'($urandom);
            d  = $urandom & ((32'd1 << nb) - 32'd1);
            if (md && ($urandom % 2 == 0)) begin
                rem = model_rem({96'd0, d}, nb, 8, 32'h07, 32'h00);
                d   = (d << 8) | rem;
                nb  = nb + 8;
            end
            rem = model_rem({96'd0, d}, nb, 8, 32'h07, 32'h00);
            run_frame8(d, nb, md, 2, 1'($urandom), rem[7:0], rem[7:0] == 8'h00);
        end

        // CRC-16/CCITT-FALSE over "123456789".
        msg = "123456789";
        for (int i = 71; i >= 0; i--) begin
            if16.enable = 1'b1;
            if16.crc_in = msg[i];
            if16.last   = (i == 0);
            tick();
        end
        if16.enable = 1'b0;
        if16.last   = 1'b0;
        chk("c16_crc_value", if16.crc_value, 16'h29B1);
        rem = model_rem({56'd0, msg}, 72, 16, 32'h1021, 32'hFFFF);
        chk("c16_model", if16.crc_value, rem[15:0]);
        got16 = 16'h0000;
        for (int k = 0; k < 16; k++) begin
            tick();
            chk("c16_append_valid", if16.out_valid, 1'b1);
            chk("c16_append_done", if16.done, k == 15);
            got16 = {got16[14:0], if16.crc_out};
        end
        chk("c16_appended", got16, 16'h29B1);
        chk("c16_in_ready", if16.in_ready, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
